// File: rtl/mem_hs_pkg.sv
// Shared definitions for the valid/ready memory handshake: FSM states, op
// encodings and the address-derived data pattern used by initiator and checkers.
package mem_hs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_REQ = 3'd1,
    ST_GAP    = 3'd2,
    ST_RD_REQ = 3'd3,
    ST_FIN    = 3'd4
  } state_t;

  localparam logic [1:0] OP_WRITE    = 2'b00;
  localparam logic [1:0] OP_CHECK    = 2'b01;
  localparam logic [1:0] OP_WR_CHECK = 2'b10;
  localparam logic [1:0] OP_RSVD     = 2'b11;

  // (seed + a*step) mod 2^width; callers cast the result down to their data width
  function automatic logic [31:0] pattern(input logic [31:0] a,
                                          input logic [31:0] seed,
                                          input logic [31:0] step,
                                          input int          width);
    logic [31:0] raw_s;
    logic [31:0] mask_s;
    raw_s = seed + (a * step);
    if (width >= 32) begin
      mask_s = 32'hFFFF_FFFF;
    end else begin
      mask_s = (32'd1 << width) - 32'd1;
    end
    return raw_s & mask_s;
  endfunction

endpackage

// File: rtl/mem_hs_watchdog.sv
// Beat watchdog: counts cycles a request waits for ready and flags expiry at
// TIMEOUT-1 so the initiator can abort on the following edge.
module mem_hs_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_r;

  assign expired = enable && (cnt_r == CNT_LAST);

  // Wait counter; saturates once expired so it never wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else if (clear) begin
      cnt_r <= CNT_ZERO;
    end else if (enable && !expired) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/mem_hs_initiator.sv
// Initiator engine for the valid/ready memory handshake: sweeps all addresses
// with a pattern write pass, a read/check pass, or both, on one start pulse.
module mem_hs_initiator
  import mem_hs_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 2,
  parameter int                    MEM_WIDTH  = 4,
  parameter int                    MEM_DEPTH  = 4,
  parameter logic [MEM_WIDTH-1:0]  SEED       = 4'h3,
  parameter logic [MEM_WIDTH-1:0]  STEP       = 4'h5,
  parameter int                    TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  output logic                  valid,
  output logic                  wr,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [MEM_WIDTH-1:0]  indata,
  input  logic                  ready,
  input  logic [MEM_WIDTH-1:0]  outdata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] first_fail_addr,
  output logic                  timeout,
  output logic [MEM_WIDTH-1:0]  rd_data,
  output logic                  rd_data_vld
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = ADDR_WIDTH'(1'b0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1'b1);
  localparam logic [ADDR_WIDTH:0]   ERR_ZERO  = (ADDR_WIDTH + 1)'(1'b0);
  localparam logic [ADDR_WIDTH:0]   ERR_ONE   = (ADDR_WIDTH + 1)'(1'b1);
  localparam logic [MEM_WIDTH-1:0]  MEM_ZERO  = MEM_WIDTH'(1'b0);

  state_t                state_r, state_s;
  logic                  check_pend_r, check_pend_s;
  logic                  valid_r, valid_s;
  logic                  wr_r, wr_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_s;
  logic [MEM_WIDTH-1:0]  indata_r, indata_s;
  logic                  busy_r, busy_s;
  logic                  done_r, done_s;
  logic                  pass_r, pass_s;
  logic [ADDR_WIDTH:0]   err_count_r, err_count_s;
  logic [ADDR_WIDTH-1:0] ffa_r, ffa_s;
  logic                  timeout_r, timeout_s;
  logic [MEM_WIDTH-1:0]  rd_data_r, rd_data_s;
  logic                  rd_data_vld_r, rd_data_vld_s;

  logic                  handshake_s;
  logic                  expired_s;
  logic [MEM_WIDTH-1:0]  pat_cur_s;
  logic [MEM_WIDTH-1:0]  pat_nxt_s;

  assign handshake_s = valid_r && ready;

  // Counter idles at zero while no request is out and restarts for every beat
  mem_hs_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (!valid_r || handshake_s),
    .enable  (valid_r),
    .expired (expired_s)
  );

  // Next-state and next-output decode
  always_comb begin
    state_s       = state_r;
    check_pend_s  = check_pend_r;
    valid_s       = valid_r;
    wr_s          = wr_r;
    addr_s        = addr_r;
    indata_s      = indata_r;
    busy_s        = busy_r;
    done_s        = 1'b0;
    pass_s        = pass_r;
    err_count_s   = err_count_r;
    ffa_s         = ffa_r;
    timeout_s     = timeout_r;
    rd_data_s     = rd_data_r;
    rd_data_vld_s = 1'b0;
    pat_cur_s     = MEM_WIDTH'(pattern(32'(addr_r), 32'(SEED), 32'(STEP), MEM_WIDTH));
    pat_nxt_s     = MEM_WIDTH'(pattern(32'(addr_r) + 32'd1, 32'(SEED), 32'(STEP), MEM_WIDTH));

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          busy_s      = 1'b1;
          valid_s     = 1'b1;
          addr_s      = ADDR_ZERO;
          err_count_s = ERR_ZERO;
          ffa_s       = ADDR_ZERO;
          timeout_s   = 1'b0;
          pass_s      = 1'b0;
          if ((op == OP_WRITE) || (op == OP_WR_CHECK)) begin
            state_s      = ST_WR_REQ;
            wr_s         = 1'b1;
            indata_s     = SEED;
            check_pend_s = (op == OP_WR_CHECK);
          end else begin
            // OP_CHECK and the reserved encoding both run a plain check pass
            state_s      = ST_RD_REQ;
            wr_s         = 1'b0;
            indata_s     = MEM_ZERO;
            check_pend_s = 1'b0;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_WR_REQ, ST_RD_REQ: begin
        if (handshake_s) begin
          if (!wr_r) begin
            rd_data_s     = outdata;
            rd_data_vld_s = 1'b1;
            if (outdata != pat_cur_s) begin
              err_count_s = err_count_r + ERR_ONE;
              if (err_count_r == ERR_ZERO) begin
                ffa_s = addr_r;
              end else begin
                ffa_s = ffa_r;
              end
            end else begin
              err_count_s = err_count_r;
            end
          end else begin
            rd_data_s = rd_data_r;
          end

          if (addr_r != LAST_ADDR) begin
            addr_s   = addr_r + ADDR_ONE;
            indata_s = wr_r ? pat_nxt_s : MEM_ZERO;
          end else if (wr_r && check_pend_r) begin
            state_s      = ST_GAP;
            valid_s      = 1'b0;
            wr_s         = 1'b0;
            addr_s       = ADDR_ZERO;
            indata_s     = MEM_ZERO;
            check_pend_s = 1'b0;
          end else begin
            state_s      = ST_FIN;
            valid_s      = 1'b0;
            wr_s         = 1'b0;
            done_s       = 1'b1;
            check_pend_s = 1'b0;
            pass_s       = (err_count_s == ERR_ZERO) && !timeout_r;
          end
        end else if (expired_s) begin
          state_s      = ST_FIN;
          timeout_s    = 1'b1;
          valid_s      = 1'b0;
          wr_s         = 1'b0;
          done_s       = 1'b1;
          pass_s       = 1'b0;
          check_pend_s = 1'b0;
        end else begin
          state_s = state_r;
        end
      end

      ST_GAP: begin
        state_s = ST_RD_REQ;
        valid_s = 1'b1;
        wr_s    = 1'b0;
        addr_s  = ADDR_ZERO;
      end

      ST_FIN: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end

      default: begin
        state_s      = ST_IDLE;
        valid_s      = 1'b0;
        wr_s         = 1'b0;
        busy_s       = 1'b0;
        check_pend_s = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      check_pend_r  <= 1'b0;
      valid_r       <= 1'b0;
      wr_r          <= 1'b0;
      addr_r        <= ADDR_ZERO;
      indata_r      <= MEM_ZERO;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      pass_r        <= 1'b0;
      err_count_r   <= ERR_ZERO;
      ffa_r         <= ADDR_ZERO;
      timeout_r     <= 1'b0;
      rd_data_r     <= MEM_ZERO;
      rd_data_vld_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      check_pend_r  <= check_pend_s;
      valid_r       <= valid_s;
      wr_r          <= wr_s;
      addr_r        <= addr_s;
      indata_r      <= indata_s;
      busy_r        <= busy_s;
      done_r        <= done_s;
      pass_r        <= pass_s;
      err_count_r   <= err_count_s;
      ffa_r         <= ffa_s;
      timeout_r     <= timeout_s;
      rd_data_r     <= rd_data_s;
      rd_data_vld_r <= rd_data_vld_s;
    end
  end

  assign valid           = valid_r;
  assign wr              = wr_r;
  assign addr            = addr_r;
  assign indata          = indata_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign pass            = pass_r;
  assign err_count       = err_count_r;
  assign first_fail_addr = ffa_r;
  assign timeout         = timeout_r;
  assign rd_data         = rd_data_r;
  assign rd_data_vld     = rd_data_vld_r;

endmodule

// File: tb/tb_mem_hs_initiator.sv
// Directed bench for mem_hs_initiator with a small responder model whose ready
// can be tied high, delayed two cycles per beat, or never asserted.
module tb_mem_hs_initiator;

  localparam int AW        = 2;
  localparam int MW        = 4;
  localparam int DEPTH     = 4;
  localparam int RDY_HIGH  = 0;
  localparam int RDY_DELAY = 1;
  localparam int RDY_NONE  = 2;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [1:0] op;
  logic valid;
  logic wr;
  logic [AW-1:0] addr;
  logic [MW-1:0] indata;
  logic ready;
  logic [MW-1:0] outdata;
  logic busy;
  logic done;
  logic pass;
  logic [AW:0] err_count;
  logic [AW-1:0] first_fail_addr;
  logic timeout;
  logic [MW-1:0] rd_data;
  logic rd_data_vld;

  logic [MW-1:0] mem [DEPTH];
  int rdy_mode;
  logic [2:0] wait_cnt = 3'd0;
  logic [21:0] all_out;

  int n_checks = 0;
  int n_errors = 0;

  logic          beat_wr   [16];
  logic [AW-1:0] beat_addr [16];
  logic [MW-1:0] beat_data [16];
  int            beat_k    [16];
  logic [MW-1:0] rd_log    [16];
  int nb, nr, gap_cnt, done_k;
  logic done_seen, done_valid, hit;

  // hand-computed pattern for SEED=3, STEP=5, 4-bit data
  logic [MW-1:0] exp_pat [DEPTH] = '{4'h3, 4'h8, 4'hD, 4'h2};
  logic [MW-1:0] exp_bad [DEPTH] = '{4'h3, 4'h8, 4'hF, 4'h2};

  mem_hs_initiator dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .op              (op),
    .valid           (valid),
    .wr              (wr),
    .addr            (addr),
    .indata          (indata),
    .ready           (ready),
    .outdata         (outdata),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .first_fail_addr (first_fail_addr),
    .timeout         (timeout),
    .rd_data         (rd_data),
    .rd_data_vld     (rd_data_vld)
  );

  always #5 clk = ~clk;

  assign outdata = mem[addr];
  assign ready   = (rdy_mode == RDY_HIGH)  ? 1'b1 :
                   (rdy_mode == RDY_DELAY) ? (valid && (wait_cnt == 3'd2)) : 1'b0;
  assign all_out = {valid, wr, addr, indata, busy, done, pass, err_count,
                    first_fail_addr, timeout, rd_data, rd_data_vld};

  always @(posedge clk) begin
    if (!valid || ready) wait_cnt <= 3'd0;
    else if (wait_cnt != 3'd7) wait_cnt <= wait_cnt + 3'd1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse start with op_v, then log every beat, read strobe and gap cycle until done
  task automatic run_op(input logic [1:0] op_v, input int budget, input int inject_k);
    int k;
    nb = 0; nr = 0; gap_cnt = 0; done_k = -1;
    done_seen = 1'b0; done_valid = 1'b1;
    @(negedge clk); start = 1'b1; op = op_v;
    @(negedge clk); start = 1'b0; op = 2'b00;
    k = 0;
    while (!done_seen && k < budget) begin
      start = (k == inject_k);
      if (valid && ready && nb < 16) begin
        beat_wr[nb] = wr; beat_addr[nb] = addr;
        beat_data[nb] = wr ? indata : outdata; beat_k[nb] = k;
        nb++;
        if (wr) mem[addr] = indata;
      end
      if (rd_data_vld && nr < 16) begin rd_log[nr] = rd_data; nr++; end
      if (busy && !valid && !done) gap_cnt++;
      if (done) begin
        done_seen = 1'b1; done_k = k; done_valid = valid;
      end else begin
        @(negedge clk); k++;
      end
    end
    start = 1'b0;
    check_eq("done_seen", 32'(done_seen), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; rdy_mode = RDY_HIGH;
    for (int i = 0; i < DEPTH; i++) mem[i] = 4'h0;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", 32'(all_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Write pass, ready tied high: one beat per cycle
    run_op(2'b00, 30, -1);
    check_eq("t1_nbeats", 32'(nb), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq("t1_beat", 32'({beat_wr[i], beat_addr[i], beat_data[i]}),
               32'({1'b1, AW'(i), exp_pat[i]}));
      check_eq("t1_beat_cycle", 32'(beat_k[i]), 32'(i));
    end
    check_eq("t1_done_cycle", 32'(done_k), 32'd4);
    check_eq("t1_done_valid", 32'(done_valid), 32'd0);
    check_eq("t1_pass", 32'(pass), 32'd1);
    check_eq("t1_gap", 32'(gap_cnt), 32'd0);
    @(negedge clk);
    check_eq("t1_busy_after", 32'({busy, pass}), 32'b01);

    // Write then check, ready delayed 2 cycles per beat
    for (int i = 0; i < DEPTH; i++) mem[i] = 4'h0;
    rdy_mode = RDY_DELAY;
    run_op(2'b10, 60, -1);
    check_eq("t2_nbeats", 32'(nb), 32'd8);
    for (int i = 0; i < 4; i++) begin
      check_eq("t2_wr_beat", 32'({beat_wr[i], beat_addr[i], beat_data[i]}),
               32'({1'b1, AW'(i), exp_pat[i]}));
      check_eq("t2_wr_cycle", 32'(beat_k[i]), 32'(2 + 3 * i));
      check_eq("t2_rd_beat", 32'({beat_wr[i+4], beat_addr[i+4], beat_data[i+4]}),
               32'({1'b0, AW'(i), exp_pat[i]}));
      check_eq("t2_rd_cycle", 32'(beat_k[i+4]), 32'(15 + 3 * i));
      check_eq("t2_rd_data", 32'(rd_log[i]), 32'(exp_pat[i]));
    end
    check_eq("t2_nreads", 32'(nr), 32'd4);
    check_eq("t2_gap", 32'(gap_cnt), 32'd1);
    check_eq("t2_done_cycle", 32'(done_k), 32'd25);
    check_eq("t2_result", 32'({pass, err_count, timeout}), 32'({1'b1, 3'd0, 1'b0}));

    // Check pass against a memory with one corrupted word
    for (int i = 0; i < DEPTH; i++) mem[i] = exp_bad[i];
    rdy_mode = RDY_HIGH;
    run_op(2'b01, 30, -1);
    check_eq("t3_nbeats", 32'(nb), 32'd4);
    check_eq("t3_nreads", 32'(nr), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq("t3_rd_data", 32'(rd_log[i]), 32'(exp_bad[i]));
      check_eq("t3_beat", 32'({beat_wr[i], beat_addr[i]}), 32'({1'b0, AW'(i)}));
    end
    check_eq("t3_err_count", 32'(err_count), 32'd1);
    check_eq("t3_first_fail", 32'(first_fail_addr), 32'd2);
    check_eq("t3_pass", 32'(pass), 32'd0);
    check_eq("t3_timeout", 32'(timeout), 32'd0);

    // ready never comes: watchdog abort
    rdy_mode = RDY_NONE;
    run_op(2'b00, 40, -1);
    check_eq("t4_done_cycle", 32'(done_k), 32'd16);
    check_eq("t4_done_valid", 32'(done_valid), 32'd0);
    check_eq("t4_timeout", 32'(timeout), 32'd1);
    check_eq("t4_pass", 32'(pass), 32'd0);
    check_eq("t4_nbeats", 32'(nb), 32'd0);
    check_eq("t4_err_count", 32'(err_count), 32'd0);

    // Reset while the read of addr 1 is outstanding
    for (int i = 0; i < DEPTH; i++) mem[i] = exp_pat[i];
    rdy_mode = RDY_DELAY;
    @(negedge clk); start = 1'b1; op = 2'b01;
    @(negedge clk); start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (valid && !wr && addr == 2'd1) hit = 1'b1;
      else @(negedge clk);
    end
    check_eq("t5_reached_addr1", 32'(hit), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t5_reset_outputs", 32'(all_out), 32'd0);
    rst = 1'b0;
    rdy_mode = RDY_HIGH;
    run_op(2'b01, 30, -1);
    check_eq("t5_rerun_result", 32'({pass, err_count, timeout}), 32'({1'b1, 3'd0, 1'b0}));
    check_eq("t5_rerun_reads", 32'(nr), 32'd4);
    check_eq("t5_rerun_done", 32'(done_k), 32'd4);

    // start (with op=write) pulsed mid-check must be ignored
    rdy_mode = RDY_DELAY;
    run_op(2'b01, 40, 4);
    check_eq("t6_nbeats", 32'(nb), 32'd4);
    for (int i = 0; i < 4; i++)
      check_eq("t6_beat", 32'({beat_wr[i], beat_addr[i]}), 32'({1'b0, AW'(i)}));
    check_eq("t6_done_cycle", 32'(done_k), 32'd12);
    check_eq("t6_pass", 32'(pass), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check_eq("t6_idle_after", 32'({busy, valid}), 32'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
